// File: rtl/alu_seq_pkg.sv
// Shared widths, state encoding and field codes for the ALU operation sequencer.
package alu_seq_pkg;
    localparam int SEQ_RN_W = 3;
    localparam int SEQ_OP_W = 2;

    typedef enum logic [2:0] {
        ST_WAIT   = 3'd0,
        ST_GET_A  = 3'd1,
        ST_GET_B  = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WR_C   = 3'd4,
        ST_WR_IMM = 3'd5
    } state_t;

    localparam logic [1:0] CMD_ALU  = 2'b00;
    localparam logic [1:0] CMD_CMP  = 2'b01;
    localparam logic [1:0] CMD_MOVI = 2'b10;
    localparam logic [1:0] CMD_MOVR = 2'b11;

    localparam logic [SEQ_OP_W-1:0] ALU_ADD  = 2'b00;
    localparam logic [SEQ_OP_W-1:0] ALU_SUB  = 2'b01;
    localparam logic [SEQ_OP_W-1:0] ALU_AND  = 2'b10;
    localparam logic [SEQ_OP_W-1:0] ALU_NOTB = 2'b11;

    localparam logic [1:0] VSEL_C   = 2'b00;
    localparam logic [1:0] VSEL_IMM = 2'b01;
endpackage

// File: rtl/alu_op_sequencer.sv
// Moore FSM issuing register-file, operand, ALU and write-back strobes for one
// latched command per start pulse; outputs depend only on state and latched fields.
import alu_seq_pkg::*;

module alu_op_sequencer #(
    parameter int RN_W = SEQ_RN_W,
    parameter int OP_W = SEQ_OP_W
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_s,
    input  logic [1:0]      i_cmd,
    input  logic [OP_W-1:0] i_op_in,
    input  logic [RN_W-1:0] i_rd,
    input  logic [RN_W-1:0] i_rn,
    input  logic [RN_W-1:0] i_rm,
    output logic            o_w,
    output logic [RN_W-1:0] o_readnum,
    output logic [RN_W-1:0] o_writenum,
    output logic            o_write,
    output logic            o_loada,
    output logic            o_loadb,
    output logic            o_loadc,
    output logic            o_loads,
    output logic            o_asel,
    output logic [1:0]      o_vsel,
    output logic [OP_W-1:0] o_alu_op
);
    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_cmd;
    logic [OP_W-1:0] r_op;
    logic [RN_W-1:0] r_rd;
    logic [RN_W-1:0] r_rn;
    logic [RN_W-1:0] r_rm;

    // Fields are captured only on acceptance so input churn while busy is harmless.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_WAIT;
            r_cmd   <= CMD_ALU;
            r_op    <= ALU_ADD;
            r_rd    <= '0;
            r_rn    <= '0;
            r_rm    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_WAIT && i_s) begin
                r_cmd <= i_cmd;
                r_op  <= i_op_in;
                r_rd  <= i_rd;
                r_rn  <= i_rn;
                r_rm  <= i_rm;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_w         = 1'b0;
        o_readnum   = '0;
        o_writenum  = '0;
        o_write     = 1'b0;
        o_loada     = 1'b0;
        o_loadb     = 1'b0;
        o_loadc     = 1'b0;
        o_loads     = 1'b0;
        o_asel      = 1'b0;
        o_vsel      = VSEL_C;
        o_alu_op    = ALU_ADD;
        case (r_state)
            ST_WAIT: begin
                o_w = 1'b1;
                if (i_s) begin
                    case (i_cmd)
                        CMD_ALU:  w_state_nxt = (i_op_in == ALU_NOTB) ? ST_GET_B : ST_GET_A;
                        CMD_CMP:  w_state_nxt = ST_GET_A;
                        CMD_MOVR: w_state_nxt = ST_GET_B;
                        default:  w_state_nxt = ST_WR_IMM;
                    endcase
                end
            end
            ST_GET_A: begin
                o_readnum   = r_rn;
                o_loada     = 1'b1;
                w_state_nxt = ST_GET_B;
            end
            ST_GET_B: begin
                o_readnum   = r_rm;
                o_loadb     = 1'b1;
                w_state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                // MOVR is 0 + B through the adder.
                if (r_cmd == CMD_MOVR) begin
                    o_asel      = 1'b1;
                    o_loadc     = 1'b1;
                    w_state_nxt = ST_WR_C;
                end else if (r_cmd == CMD_CMP) begin
                    o_alu_op    = r_op;
                    o_loads     = 1'b1;
                    w_state_nxt = ST_WAIT;
                end else begin
                    o_alu_op    = r_op;
                    o_loadc     = 1'b1;
                    w_state_nxt = ST_WR_C;
                end
            end
            ST_WR_C: begin
                o_writenum  = r_rd;
                o_vsel      = VSEL_C;
                o_write     = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WR_IMM: begin
                o_writenum  = r_rd;
                o_vsel      = VSEL_IMM;
                o_write     = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            default: w_state_nxt = ST_WAIT;
        endcase
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench: strobe sequences per command plus a small datapath model driven by the strobes.
module tb_alu_op_sequencer;
    logic       clk = 1'b0;
    logic       reset;
    logic       s;
    logic [1:0] cmd;
    logic [1:0] op_in;
    logic [2:0] rd, rn, rm;
    logic       w, write, loada, loadb, loadc, loads, asel;
    logic [2:0] readnum, writenum;
    logic [1:0] vsel, alu_op;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .i_clk(clk), .i_reset(reset), .i_s(s), .i_cmd(cmd), .i_op_in(op_in),
        .i_rd(rd), .i_rn(rn), .i_rm(rm),
        .o_w(w), .o_readnum(readnum), .o_writenum(writenum), .o_write(write),
        .o_loada(loada), .o_loadb(loadb), .o_loadc(loadc), .o_loads(loads),
        .o_asel(asel), .o_vsel(vsel), .o_alu_op(alu_op)
    );

    // Datapath model: register file, A/B/C, status Z, combinational ALU.
    logic [15:0] R [8];
    logic [15:0] A = '0, B = '0, C = '0;
    logic        Z = 1'b0;
    logic [15:0] imm = '0;
    logic        pre_en = 1'b0;
    logic [2:0]  pre_addr = '0;
    logic [15:0] pre_data = '0;
    logic [15:0] ain, alu_out;

    always_comb begin
        ain = asel ? 16'd0 : A;
        case (alu_op)
            2'b00:   alu_out = ain + B;
            2'b01:   alu_out = ain - B;
            2'b10:   alu_out = ain & B;
            default: alu_out = ~B;
        endcase
    end

    always @(posedge clk) begin
        if (pre_en) R[pre_addr] <= pre_data;
        else begin
            if (loada) A <= R[readnum];
            if (loadb) B <= R[readnum];
            if (loadc) C <= alu_out;
            if (loads) Z <= (alu_out == 16'd0);
            if (write) R[writenum] <= (vsel == 2'b01) ? imm : C;
        end
    end

    // Accepted commands = falling edges of w; strobe counter for the abort check.
    int   n_acc = 0;
    int   n_cw  = 0;
    logic prev_w = 1'b1;
    always @(negedge clk) begin
        if (prev_w && !w) n_acc <= n_acc + 1;
        prev_w <= w;
    end
    always @(posedge clk) if (loadc || write) n_cw <= n_cw + 1;

    function automatic logic [15:0] pk(input logic la, lb, lc, ls, wr, as,
                                       input logic [1:0] vs, op, input logic [2:0] rnum, wnum);
        return {la, lb, lc, ls, wr, as, vs, op, rnum, wnum};
    endfunction

    logic [15:0] outs;
    assign outs = {loada, loadb, loadc, loads, write, asel, vsel, alu_op, readnum, writenum};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [1:0]       cmd;
        logic [1:0]       op;
        logic [2:0]       rd, rn, rm;
        logic [15:0]      imm;
        logic [2:0]       nbusy;
        logic [3:0][15:0] exp;
        logic [2:0]       chk_reg;
        logic [15:0]      chk_val;
        logic             chk_z;
    } vec_t;

    vec_t vt [8];

    function automatic vec_t mkv(input logic [1:0] c, o, input logic [2:0] d, n, m,
                                 input logic [15:0] im, input logic [2:0] nb,
                                 input logic [15:0] e0, e1, e2, e3,
                                 input logic [2:0] cr, input logic [15:0] cv, input logic cz);
        vec_t v;
        v.cmd = c; v.op = o; v.rd = d; v.rn = n; v.rm = m; v.imm = im; v.nbusy = nb;
        v.exp = {e3, e2, e1, e0};
        v.chk_reg = cr; v.chk_val = cv; v.chk_z = cz;
        return v;
    endfunction

    // Called just after a negedge with the DUT in WAIT.
    task automatic run_vec(input int idx, input vec_t v);
        cmd = v.cmd; op_in = v.op; rd = v.rd; rn = v.rn; rm = v.rm; imm = v.imm; s = 1'b1;
        for (int k = 0; k < int'(v.nbusy); k++) begin
            @(negedge clk);
            chk($sformatf("v%0d c%0d w", idx, k), {31'd0, w}, 32'd0);
            chk($sformatf("v%0d c%0d strobes", idx, k), {16'd0, outs}, {16'd0, v.exp[k]});
            cmd = 2'($urandom); op_in = 2'($urandom); rd = 3'($urandom);
            rn = 3'($urandom); rm = 3'($urandom); s = 1'b1;
        end
        @(negedge clk);
        chk($sformatf("v%0d back w", idx), {31'd0, w}, 32'd1);
        chk($sformatf("v%0d back idle", idx), {16'd0, outs}, 32'd0);
        s = 1'b0;
        chk($sformatf("v%0d R%0d", idx, v.chk_reg), {16'd0, R[v.chk_reg]}, {16'd0, v.chk_val});
        chk($sformatf("v%0d Z", idx), {31'd0, Z}, {31'd0, v.chk_z});
    endtask

    logic [15:0] init_r [8];

    initial begin
        init_r = '{16'h0000, 16'h0005, 16'h0007, 16'h0000, 16'h1111, 16'h5555, 16'h0000, 16'h1111};
        //                cmd   op     rd    rn    rm    imm       nb  cycle strobes ...                                                                                   chk
        vt[0] = mkv(2'b00, 2'b00, 3'd3, 3'd1, 3'd2, 16'h0, 3'd4,
                    pk(1,0,0,0,0,0,0,0,1,0), pk(0,1,0,0,0,0,0,0,2,0), pk(0,0,1,0,0,0,0,0,0,0), pk(0,0,0,0,1,0,0,0,0,3), 3'd3, 16'h000C, 1'b0);
        vt[1] = mkv(2'b01, 2'b01, 3'd3, 3'd7, 3'd4, 16'h0, 3'd3,
                    pk(1,0,0,0,0,0,0,0,7,0), pk(0,1,0,0,0,0,0,0,4,0), pk(0,0,0,1,0,0,0,1,0,0), 16'h0, 3'd3, 16'h000C, 1'b1);
        vt[2] = mkv(2'b10, 2'b00, 3'd4, 3'd0, 3'd0, 16'hFFFF, 3'd1,
                    pk(0,0,0,0,1,0,1,0,0,4), 16'h0, 16'h0, 16'h0, 3'd4, 16'hFFFF, 1'b1);
        vt[3] = mkv(2'b00, 2'b11, 3'd6, 3'd1, 3'd5, 16'h0, 3'd3,
                    pk(0,1,0,0,0,0,0,0,5,0), pk(0,0,1,0,0,0,0,3,0,0), pk(0,0,0,0,1,0,0,0,0,6), 16'h0, 3'd6, 16'hAAAA, 1'b1);
        vt[4] = mkv(2'b11, 2'b10, 3'd0, 3'd2, 3'd3, 16'h0, 3'd3,
                    pk(0,1,0,0,0,0,0,0,3,0), pk(0,0,1,0,0,1,0,0,0,0), pk(0,0,0,0,1,0,0,0,0,0), 16'h0, 3'd0, 16'h000C, 1'b1);
        vt[5] = mkv(2'b00, 2'b01, 3'd1, 3'd1, 3'd2, 16'h0, 3'd4,
                    pk(1,0,0,0,0,0,0,0,1,0), pk(0,1,0,0,0,0,0,0,2,0), pk(0,0,1,0,0,0,0,1,0,0), pk(0,0,0,0,1,0,0,0,0,1), 3'd1, 16'hFFFE, 1'b1);
        vt[6] = mkv(2'b01, 2'b00, 3'd1, 3'd1, 3'd2, 16'h0, 3'd3,
                    pk(1,0,0,0,0,0,0,0,1,0), pk(0,1,0,0,0,0,0,0,2,0), pk(0,0,0,1,0,0,0,0,0,0), 16'h0, 3'd1, 16'hFFFE, 1'b0);
        vt[7] = mkv(2'b00, 2'b10, 3'd2, 3'd5, 3'd2, 16'h0, 3'd4,
                    pk(1,0,0,0,0,0,0,0,5,0), pk(0,1,0,0,0,0,0,0,2,0), pk(0,0,1,0,0,0,0,2,0,0), pk(0,0,0,0,1,0,0,0,0,2), 3'd2, 16'h0005, 1'b0);

        reset = 1'b1; s = 1'b1; cmd = 2'b00; op_in = 2'b00; rd = '0; rn = '0; rm = '0;
        // Reset held while the model register file is preloaded; s=1 must be ignored.
        for (int i = 0; i < 8; i++) begin
            pre_en = 1'b1; pre_addr = 3'(i); pre_data = init_r[i];
            @(negedge clk);
            if (i >= 1) begin
                chk("reset w", {31'd0, w}, 32'd1);
                chk("reset idle", {16'd0, outs}, 32'd0);
            end
        end
        pre_en = 1'b0; reset = 1'b0; s = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("post-reset w", {31'd0, w}, 32'd1);
            chk("post-reset idle", {16'd0, outs}, 32'd0);
        end

        for (int i = 0; i < 8; i++) run_vec(i, vt[i]);

        // s held high: MOVI accepted on every WAIT cycle.
        cmd = 2'b10; rd = 3'd5; imm = 16'h1234; s = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("b2b c%0d w", k), {31'd0, w}, {31'd0, k[0]});
            chk($sformatf("b2b c%0d write", k), {31'd0, write}, {31'd0, ~k[0]});
        end
        s = 1'b0;
        chk("b2b R5", {16'd0, R[5]}, 32'h1234);

        // Reset in the GET_B cycle aborts the command with no loadc/write.
        cmd = 2'b00; op_in = 2'b00; rd = 3'd3; rn = 3'd1; rm = 3'd2; s = 1'b1;
        @(negedge clk);
        s = 1'b0;
        chk("abort GET_A", {16'd0, outs}, {16'd0, pk(1,0,0,0,0,0,0,0,1,0)});
        @(negedge clk);
        chk("abort GET_B", {16'd0, outs}, {16'd0, pk(0,1,0,0,0,0,0,0,2,0)});
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort w", {31'd0, w}, 32'd1);
        chk("abort idle", {16'd0, outs}, 32'd0);
        begin
            int cw0;
            cw0 = n_cw;
            repeat (5) @(negedge clk);
            chk("abort no loadc/write", n_cw - cw0, 32'd0);
            chk("abort idle w", {31'd0, w}, 32'd1);
        end
        chk("abort R3 kept", {16'd0, R[3]}, 32'h000C);
        chk("accepted count", n_acc, 32'd11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
